// File: rtl/tour_cmd.sv
// Replays a stored knight's tour as vertical/fanfare command pairs, muxed with UART commands when idle.
// cmd_rdy rises 1 clk after start_tour; each leg is held until clr_cmd_rdy, then waits for send_resp.
module tour_cmd #(
  parameter int         NUM_MOVES  = 24,
  parameter logic [3:0] OP_MOVE    = 4'h2,
  parameter logic [3:0] OP_FANFARE = 4'h3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_tour,
  input  logic [7:0]  move,
  output logic [4:0]  mv_indx,
  input  logic [15:0] cmd_UART,
  input  logic        cmd_rdy_UART,
  input  logic        clr_cmd_rdy,
  input  logic        send_resp,
  output logic [15:0] cmd,
  output logic        cmd_rdy,
  output logic [7:0]  resp
);

  localparam logic [7:0] HEAD_N = 8'h00;
  localparam logic [7:0] HEAD_W = 8'h3F;
  localparam logic [7:0] HEAD_S = 8'h7F;
  localparam logic [7:0] HEAD_E = 8'hBF;
  localparam logic [4:0] LAST_INDX = 5'(NUM_MOVES - 1);

  typedef enum logic [2:0] {IDLE, VERT, HOLDV, HORZ, HOLDH} state_t;

  state_t      r_state;
  logic [4:0]  r_mv_indx;
  logic [7:0]  w_vhead, w_hhead;
  logic [3:0]  w_vsq, w_hsq;
  logic [15:0] w_vcmd, w_hcmd;
  logic        w_last;

  assign mv_indx = r_mv_indx;
  assign w_last  = (r_mv_indx == LAST_INDX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_mv_indx <= '0;
    end else begin
      case (r_state)
        IDLE: if (start_tour) begin
          r_mv_indx <= '0;
          r_state   <= VERT;
        end
        VERT:  if (clr_cmd_rdy) r_state <= HOLDV;
        HOLDV: if (send_resp)   r_state <= HORZ;
        HORZ:  if (clr_cmd_rdy) r_state <= HOLDH;
        HOLDH: if (send_resp) begin
          if (w_last) begin
            r_mv_indx <= '0;
            r_state   <= IDLE;
          end else begin
            r_mv_indx <= r_mv_indx + 5'd1;
            r_state   <= VERT;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Lowest set bit wins so a corrupted (multi-hot) move still yields a legal leg pair.
  always_comb begin
    w_vhead = HEAD_N;
    w_vsq   = 4'd0;
    w_hhead = HEAD_E;
    w_hsq   = 4'd0;
    if (move[0]) begin
      w_vhead = HEAD_N; w_vsq = 4'd2; w_hhead = HEAD_E; w_hsq = 4'd1;
    end else if (move[1]) begin
      w_vhead = HEAD_N; w_vsq = 4'd2; w_hhead = HEAD_W; w_hsq = 4'd1;
    end else if (move[2]) begin
      w_vhead = HEAD_N; w_vsq = 4'd1; w_hhead = HEAD_W; w_hsq = 4'd2;
    end else if (move[3]) begin
      w_vhead = HEAD_S; w_vsq = 4'd1; w_hhead = HEAD_W; w_hsq = 4'd2;
    end else if (move[4]) begin
      w_vhead = HEAD_S; w_vsq = 4'd2; w_hhead = HEAD_W; w_hsq = 4'd1;
    end else if (move[5]) begin
      w_vhead = HEAD_S; w_vsq = 4'd2; w_hhead = HEAD_E; w_hsq = 4'd1;
    end else if (move[6]) begin
      w_vhead = HEAD_S; w_vsq = 4'd1; w_hhead = HEAD_E; w_hsq = 4'd2;
    end else if (move[7]) begin
      w_vhead = HEAD_N; w_vsq = 4'd1; w_hhead = HEAD_E; w_hsq = 4'd2;
    end
  end

  assign w_vcmd = {OP_MOVE, w_vhead, w_vsq};
  assign w_hcmd = {OP_FANFARE, w_hhead, w_hsq};

  always_comb begin
    cmd     = cmd_UART;
    cmd_rdy = cmd_rdy_UART;
    case (r_state)
      VERT:    begin cmd = w_vcmd; cmd_rdy = 1'b1; end
      HOLDV:   begin cmd = w_vcmd; cmd_rdy = 1'b0; end
      HORZ:    begin cmd = w_hcmd; cmd_rdy = 1'b1; end
      HOLDH:   begin cmd = w_hcmd; cmd_rdy = 1'b0; end
      default: begin cmd = cmd_UART; cmd_rdy = cmd_rdy_UART; end
    endcase
  end

  assign resp = ((r_state == IDLE) || ((r_state == HOLDH) && w_last)) ? 8'hA5 : 8'h5A;

endmodule
